// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: label width, reserved and station labels,
// memory op encoding and the memory execution unit state encoding.
package tomasulo_pkg;

  localparam int LABEL_W = 5;

  localparam logic [LABEL_W-1:0] LABEL_NONE = 5'd0;
  localparam logic [LABEL_W-1:0] q0 = 5'd1;
  localparam logic [LABEL_W-1:0] q1 = 5'd2;
  localparam logic [LABEL_W-1:0] q2 = 5'd3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BCAST  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_exec_unit_mem_array.sv
// Single-port synchronous word RAM; read data appears one cycle after a read
// is issued and holds until the next read.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Memory execution unit: accepts one station entry, accesses the local RAM
// after LAT cycles, then broadcasts on the CDB. Option: MEM_STORE_BCAST_EN.
import tomasulo_pkg::*;

module mem_exec_unit #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               require,
  output logic               requireAC,
  input  logic               opIn,
  input  logic [31:0]        addrIn,
  input  logic [31:0]        wdataIn,
  input  logic [LABEL_W-1:0] labelIn,
  input  logic               bcGrant,
  output logic               BCEN,
  output logic [LABEL_W-1:0] BClabel,
  output logic [31:0]        BCdata,
  output logic               busy
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  mem_state_t         state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               op_q;
  logic [AW-1:0]      idx_q;
  logic [31:0]        wdata_q;
  logic [LABEL_W-1:0] label_q;
  logic               accept, skip_bc, mem_we, mem_re;
  logic [31:0]        rdata;
  logic               unused_addr;

  assign accept      = require && requireAC;
  assign unused_addr = ^{addrIn[31:AW+2], addrIn[1:0]};

`ifdef MEM_STORE_BCAST_EN
  assign skip_bc = (label_q == LABEL_NONE);
`else
  assign skip_bc = (label_q == LABEL_NONE) || (op_q == OP_STORE);
`endif

  // Accept stage: entry fields captured on the handshake edge
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= opIn;
      idx_q   <= addrIn[AW+1:2];
      wdata_q <= wdataIn;
      label_q <= labelIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    requireAC = 1'b0;
    busy      = 1'b0;
    BCEN      = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        requireAC = 1'b1;
        if (require) begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_INIT;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          // A reset landing on the access cycle must not let the write through
          mem_we    = nRST && (op_q == OP_STORE);
          mem_re    = (op_q == OP_LOAD);
          state_nxt = skip_bc ? IDLE : BCAST;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      BCAST: begin
        busy = 1'b1;
        BCEN = 1'b1;
        if (bcGrant) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Broadcast stage: RAM read port holds the load data for the whole BCAST
  assign BClabel = BCEN ? label_q : '0;
  assign BCdata  = (BCEN && (op_q == OP_LOAD)) ? rdata : 32'd0;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_exec_unit.sv
// Self-checking bench for mem_exec_unit with a broadcast scoreboard and a
// shadow memory model; honours MEM_STORE_BCAST_EN.
import tomasulo_pkg::*;

module tb_mem_exec_unit;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  label;
    logic [31:0] data;
  } bc_t;

  logic        clk = 1'b0;
  logic        nRST;
  logic        require;
  logic        requireAC;
  logic        opIn;
  logic [31:0] addrIn;
  logic [31:0] wdataIn;
  logic [4:0]  labelIn;
  logic        bcGrant;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bc_t         sb[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  mem_exec_unit #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .require   (require),
    .requireAC (requireAC),
    .opIn      (opIn),
    .addrIn    (addrIn),
    .wdataIn   (wdataIn),
    .labelIn   (labelIn),
    .bcGrant   (bcGrant),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata),
    .busy      (busy)
  );

  task automatic run_op(input logic op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] label, input int stall, input bit hold);
    bc_t  exp, got;
    logic exp_bc;
    int   guard;
    int   widx;
    guard = 0;
    widx  = int'(addr[AW+1:2]);
    while (requireAC !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (requireAC !== 1'b1) begin
      fails++;
      $display("FAIL accept_wait: requireAC=%b expected 1", requireAC);
    end
    require = 1'b1; opIn = op; addrIn = addr; wdataIn = wdata; labelIn = label;
`ifdef MEM_STORE_BCAST_EN
    exp_bc = (label != 5'd0);
`else
    exp_bc = (label != 5'd0) && (op == OP_LOAD);
`endif
    exp.label = label;
    exp.data  = (op == OP_LOAD) ? model[widx] : 32'h0;
    if (op == OP_STORE) model[widx] = wdata;
    if (exp_bc) sb.push_back(exp);
    bcGrant = 1'b1;
    @(negedge clk);
    if (!hold) require = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tests++;
      if ({busy, requireAC, BCEN} !== 3'b100) begin
        fails++;
        $display("FAIL access_c%0d: busy/requireAC/BCEN=%b expected 100", k, {busy, requireAC, BCEN});
      end
      @(negedge clk);
    end
    if (exp_bc) begin
      if (stall > 0) bcGrant = 1'b0;
      got = {BClabel, BCdata};
      tests++;
      if (BCEN !== 1'b1 || sb.size() == 0) begin
        fails++;
        $display("FAIL bcast_start: BCEN=%b expected 1 (pending=%0d)", BCEN, sb.size());
      end else begin
        exp = sb.pop_front();
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL bcast_value: label=%0d data=%h expected label=%0d data=%h",
                   got.label, got.data, exp.label, exp.data);
        end
      end
      for (int s = 1; s <= stall; s++) begin
        @(negedge clk);
        if (s == stall) bcGrant = 1'b1;
        tests++;
        if ({BCEN, BClabel, BCdata} !== {1'b1, got}) begin
          fails++;
          $display("FAIL stall_hold_%0d: BCEN=%b label=%0d data=%h expected 1/%0d/%h",
                   s, BCEN, BClabel, BCdata, got.label, got.data);
        end
      end
      @(negedge clk);
      require = 1'b0;
      tests++;
      if ({BCEN, requireAC, busy} !== 3'b010 || {BClabel, BCdata} !== 37'd0) begin
        fails++;
        $display("FAIL bcast_done: BCEN/requireAC/busy=%b label=%0d data=%h expected 010/0/0",
                 {BCEN, requireAC, busy}, BClabel, BCdata);
      end
    end else begin
      require = 1'b0;
      tests++;
      if ({BCEN, requireAC, busy} !== 3'b010) begin
        fails++;
        $display("FAIL no_bcast: BCEN/requireAC/busy=%b expected 010", {BCEN, requireAC, busy});
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; require = 1'b0; opIn = 1'b0; addrIn = '0; wdataIn = '0; labelIn = '0;
    bcGrant = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({requireAC, busy, BCEN, BClabel, BCdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: requireAC=%b busy=%b BCEN=%b label=%0d data=%h expected 1 0 0 0 0",
               requireAC, busy, BCEN, BClabel, BCdata);
    end
    nRST = 1'b1;
    bcGrant = 1'b1;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if ({BCEN, busy, requireAC} !== 3'b001) begin
        fails++;
        $display("FAIL idle_grant: BCEN/busy/requireAC=%b expected 001", {BCEN, busy, requireAC});
      end
    end
  endtask

  task automatic test_store_load();
    run_op(OP_STORE, 32'h10, 32'hDEADBEEF, 5'd5, 0, 1'b0);
    run_op(OP_LOAD,  32'h10, 32'h0,        5'd6, 0, 1'b0);
  endtask

  task automatic test_grant_stall();
    run_op(OP_STORE, 32'h20, 32'hCAFE0009, 5'd0, 0, 1'b0);
    run_op(OP_LOAD,  32'h20, 32'h0,        5'd9, 4, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_op(OP_STORE, 32'h100, 32'h1234, 5'd2, 0, 1'b0);
    run_op(OP_LOAD,  32'h000, 32'h0,    5'd7, 0, 1'b0);
    run_op(OP_STORE, 32'h010, 32'h0BAD0004, 5'd0, 0, 1'b0);
    run_op(OP_LOAD,  32'hFFFF_FF13, 32'h0, 5'd8, 1, 1'b0);
  endtask

  task automatic test_label0();
    run_op(OP_LOAD, 32'h10, 32'h0, 5'd0, 0, 1'b0);
  endtask

  task automatic test_reset_access();
    run_op(OP_STORE, 32'hC, 32'h5555, 5'd0, 0, 1'b0);
    require = 1'b1; opIn = OP_STORE; addrIn = 32'hC; wdataIn = 32'hAAAA; labelIn = 5'd3;
    @(negedge clk);
    require = 1'b0;
    nRST = 1'b0;
    @(negedge clk);
    tests++;
    if ({requireAC, busy, BCEN, BClabel, BCdata} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_mid: requireAC=%b busy=%b BCEN=%b label=%0d data=%h expected 1 0 0 0 0",
               requireAC, busy, BCEN, BClabel, BCdata);
    end
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    run_op(OP_LOAD, 32'hC, 32'h0, 5'd10, 0, 1'b0);
  endtask

  task automatic test_macro();
    run_op(OP_STORE, 32'h40, 32'h77778888, 5'd4, 0, 1'b0);
  endtask

  task automatic test_require_held();
    run_op(OP_LOAD,  32'h40, 32'h0,  5'd11, 2, 1'b1);
    run_op(OP_STORE, 32'h44, 32'h99, 5'd12, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 4; i++)
      run_op(OP_STORE, 32'h80 + 32'(i * 4), $urandom, 5'($urandom_range(0, 31)), 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a = 32'h80 + 32'($urandom_range(0, 3) * 4);
      run_op(1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_grant_stall();
    test_addr_wrap();
    test_label0();
    test_reset_access();
    test_macro();
    test_require_held();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d broadcasts pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
